load_store_unit: RTL and testbench

LOAD_STORE_UNIT -- requirements
Module: load_store_unit

---
 rtl/load_store_unit_pkg.sv | 49 ++++
 rtl/lsu_load_align.sv | 34 +++
 rtl/load_store_unit.sv | 162 ++++++++++++++++
 tb/tb_load_store_unit.sv | 320 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/load_store_unit_pkg.sv
// Shared definitions for the RV32I load/store unit: funct3 encodings,
// FSM state encoding and the access-size decode helper.
package load_store_unit_pkg;

    localparam logic [2:0] LSU_F3_LB  = 3'b000;
    localparam logic [2:0] LSU_F3_LH  = 3'b001;
    localparam logic [2:0] LSU_F3_LW  = 3'b010;
    localparam logic [2:0] LSU_F3_LBU = 3'b100;
    localparam logic [2:0] LSU_F3_LHU = 3'b101;
    localparam logic [2:0] LSU_F3_SB  = 3'b000;
    localparam logic [2:0] LSU_F3_SH  = 3'b001;
    localparam logic [2:0] LSU_F3_SW  = 3'b010;

    typedef enum logic [1:0] {
        LSU_IDLE  = 2'd0,
        LSU_ISSUE = 2'd1,
        LSU_WAIT  = 2'd2,
        LSU_RESP  = 2'd3
    } lsu_state_e;

    typedef enum logic [1:0] {
        SIZE_BYTE = 2'd0,
        SIZE_HALF = 2'd1,
        SIZE_WORD = 2'd2
    } access_size_e;

    // Unrecognised funct3 values fall back to a word access.
    function automatic access_size_e access_size(input logic is_store, input logic [2:0] funct3);
        access_size_e size;
        size = SIZE_WORD;
        if (is_store) begin
            case (funct3)
                LSU_F3_SB: size = SIZE_BYTE;
                LSU_F3_SH: size = SIZE_HALF;
                LSU_F3_SW: size = SIZE_WORD;
                default:   size = SIZE_WORD;
            endcase
        end else begin
            case (funct3)
                LSU_F3_LB, LSU_F3_LBU: size = SIZE_BYTE;
                LSU_F3_LH, LSU_F3_LHU: size = SIZE_HALF;
                LSU_F3_LW:             size = SIZE_WORD;
                default:               size = SIZE_WORD;
            endcase
        end
        return size;
    endfunction

endpackage

// File: rtl/lsu_load_align.sv
// Combinational load lane selection and sign/zero extension for RV32I loads.
module lsu_load_align
    import load_store_unit_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  offset,
    input  logic [2:0]  funct3,
    output logic [31:0] value
);

    access_size_e size;
    logic [31:0]  byte_shift;
    logic [31:0]  half_shift;
    logic         sign_ext;

    assign size       = access_size(1'b0, funct3);
    assign byte_shift = word >> {offset, 3'b000};
    // Halfword lane comes from addr[1] alone; addr[0] never moves the lane.
    assign half_shift = word >> {offset[1], 4'b0000};
    assign sign_ext   = (funct3 == LSU_F3_LB) || (funct3 == LSU_F3_LH);

    // NOTE: value gets a default first so no path through the case can infer a latch.
    always_comb begin
        value = word;
        case (size)
            SIZE_BYTE: value = sign_ext ? {{24{byte_shift[7]}}, byte_shift[7:0]}
                                        : {24'b0, byte_shift[7:0]};
            SIZE_HALF: value = sign_ext ? {{16{half_shift[15]}}, half_shift[15:0]}
                                        : {16'b0, half_shift[15:0]};
            default:   value = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: one outstanding access between execute and the memory arbiter.
// Optional feature macro: LSU_MISALIGN_TRAP_EN (trap misaligned half/word accesses).
module load_store_unit
    import load_store_unit_pkg::*;
#(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
) (
    input  logic                  CLK,
    input  logic                  RST,
    input  logic                  req_valid,
    output logic                  req_ready,
    input  logic                  req_is_store,
    input  logic [2:0]            req_funct3,
    input  logic [ADDR_WIDTH-1:0] req_addr,
    input  logic [DATA_WIDTH-1:0] req_wdata,
    input  logic [4:0]            req_rd,
    output logic                  resp_valid,
    input  logic                  resp_ready,
    output logic [DATA_WIDTH-1:0] resp_data,
    output logic [4:0]            resp_rd,
    output logic                  resp_misaligned,
    output logic                  ls_valid,
    input  logic                  ls_ready,
    output logic [ADDR_WIDTH-1:0] ls_addr,
    output logic                  ls_is_write,
    output logic [3:0]            ls_strobe,
    output logic [DATA_WIDTH-1:0] ls_wdata,
    input  logic                  ls_result_valid,
    output logic                  ls_result_ready,
    input  logic [DATA_WIDTH-1:0] ls_load_data
);

    lsu_state_e            state_q, state_d;
    logic                  is_store_q;
    logic [2:0]            funct3_q;
    logic [ADDR_WIDTH-1:0] addr_q;
    logic [DATA_WIDTH-1:0] wdata_q;
    logic [4:0]            rd_q;
    logic [DATA_WIDTH-1:0] resp_data_q;
    logic [DATA_WIDTH-1:0] load_value;
    logic [3:0]            strobe_d;
    logic [DATA_WIDTH-1:0] wdata_d;
    access_size_e          size_q;
    logic                  req_fault;
    logic                  accept;
    logic                  capture;

`ifdef LSU_MISALIGN_TRAP_EN
    access_size_e req_size;
    logic         resp_mis_q;

    assign req_size  = access_size(req_is_store, req_funct3);
    assign req_fault = ((req_size == SIZE_HALF) && req_addr[0]) ||
                       ((req_size == SIZE_WORD) && (req_addr[1:0] != 2'b00));
    assign resp_misaligned = resp_mis_q;
`else
    assign req_fault       = 1'b0;
    assign resp_misaligned = 1'b0;
`endif

    assign accept  = req_valid && req_ready;
    assign capture = ls_result_valid && ls_result_ready;
    assign size_q  = access_size(is_store_q, funct3_q);

    always_comb begin
        state_d         = state_q;
        req_ready       = 1'b0;
        ls_valid        = 1'b0;
        ls_result_ready = 1'b0;
        resp_valid      = 1'b0;
        case (state_q)
            LSU_IDLE: begin
                req_ready = 1'b1;
                if (req_valid) state_d = req_fault ? LSU_RESP : LSU_ISSUE;
            end
            LSU_ISSUE: begin
                ls_valid = 1'b1;
                if (ls_ready) state_d = LSU_WAIT;
            end
            LSU_WAIT: begin
                ls_result_ready = 1'b1;
                if (ls_result_valid) state_d = LSU_RESP;
            end
            LSU_RESP: begin
                resp_valid = 1'b1;
                if (resp_ready) state_d = LSU_IDLE;
            end
            default: state_d = LSU_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) state_q <= LSU_IDLE;
        else     state_q <= state_d;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            is_store_q  <= 1'b0;
            funct3_q    <= 3'b000;
            addr_q      <= '0;
            wdata_q     <= '0;
            rd_q        <= 5'd0;
            resp_data_q <= '0;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_mis_q  <= 1'b0;
`endif
        end else if (accept) begin
            is_store_q <= req_is_store;
            funct3_q   <= req_funct3;
            addr_q     <= req_addr;
            wdata_q    <= req_wdata;
            rd_q       <= req_rd;
`ifdef LSU_MISALIGN_TRAP_EN
            resp_mis_q <= req_fault;
            if (req_fault) resp_data_q <= DATA_WIDTH'(req_addr);
`endif
        end else if (capture) begin
            resp_data_q <= is_store_q ? '0 : load_value;
        end
    end

    lsu_load_align u_load_align (
        .word   (ls_load_data),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .value  (load_value)
    );

    always_comb begin
        strobe_d = 4'b0000;
        wdata_d  = '0;
        if (is_store_q) begin
            case (size_q)
                SIZE_BYTE: begin
                    strobe_d = 4'b0001 << addr_q[1:0];
                    wdata_d  = {4{wdata_q[7:0]}};
                end
                SIZE_HALF: begin
                    strobe_d = 4'b0011 << {addr_q[1], 1'b0};
                    wdata_d  = {2{wdata_q[15:0]}};
                end
                default: begin
                    strobe_d = 4'b1111;
                    wdata_d  = wdata_q;
                end
            endcase
        end
    end

    // Arbiter-facing fields are driven only while a request is being offered.
    assign ls_addr     = ls_valid ? {addr_q[ADDR_WIDTH-1:2], 2'b00} : '0;
    assign ls_is_write = ls_valid && is_store_q;
    assign ls_strobe   = ls_valid ? strobe_d : 4'b0000;
    assign ls_wdata    = ls_valid ? wdata_d : '0;

    assign resp_data = resp_data_q;
    assign resp_rd   = rd_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: directed vector table, hand-written
// corner sequences and randomized transactions against a behavioural model.
module tb_load_store_unit;

    logic        CLK = 1'b0;
    logic        RST = 1'b1;
    logic        req_valid = 1'b0;
    logic        req_ready;
    logic        req_is_store = 1'b0;
    logic [2:0]  req_funct3 = 3'b000;
    logic [31:0] req_addr = 32'h0;
    logic [31:0] req_wdata = 32'h0;
    logic [4:0]  req_rd = 5'd0;
    logic        resp_valid;
    logic        resp_ready = 1'b0;
    logic [31:0] resp_data;
    logic [4:0]  resp_rd;
    logic        resp_misaligned;
    logic        ls_valid;
    logic        ls_ready = 1'b0;
    logic [31:0] ls_addr;
    logic        ls_is_write;
    logic [3:0]  ls_strobe;
    logic [31:0] ls_wdata;
    logic        ls_result_valid = 1'b0;
    logic        ls_result_ready;
    logic [31:0] ls_load_data = 32'h0;

    int n_assert = 0;
    int n_fail   = 0;
    int hs_count = 0;

    typedef struct {
        bit          st;
        bit [2:0]    f3;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] ld;
        logic [4:0]  rd;
        int          ls_stall;
        int          resp_stall;
    } req_t;

    typedef struct {
        bit          fault;
        logic [31:0] ls_addr;
        logic [3:0]  strobe;
        logic [31:0] wdata;
        logic [31:0] data;
    } exp_t;

    typedef struct {
        req_t r;
        exp_t e;
    } vec_t;

    vec_t tbl[12];

    load_store_unit #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) dut (
        .CLK             (CLK),
        .RST             (RST),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_is_store    (req_is_store),
        .req_funct3      (req_funct3),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .resp_valid      (resp_valid),
        .resp_ready      (resp_ready),
        .resp_data       (resp_data),
        .resp_rd         (resp_rd),
        .resp_misaligned (resp_misaligned),
        .ls_valid        (ls_valid),
        .ls_ready        (ls_ready),
        .ls_addr         (ls_addr),
        .ls_is_write     (ls_is_write),
        .ls_strobe       (ls_strobe),
        .ls_wdata        (ls_wdata),
        .ls_result_valid (ls_result_valid),
        .ls_result_ready (ls_result_ready),
        .ls_load_data    (ls_load_data)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) if (ls_valid && ls_ready) hs_count++;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic req_t mk_req(bit st, bit [2:0] f3, logic [31:0] addr, logic [31:0] wdata,
                                    logic [31:0] ld, logic [4:0] rd, int ls_stall, int resp_stall);
        req_t r;
        r.st = st; r.f3 = f3; r.addr = addr; r.wdata = wdata; r.ld = ld; r.rd = rd;
        r.ls_stall = ls_stall; r.resp_stall = resp_stall;
        return r;
    endfunction

    function automatic exp_t mk_exp(bit fault, logic [31:0] la, logic [3:0] strobe,
                                    logic [31:0] wdata, logic [31:0] data);
        exp_t e;
        e.fault = fault; e.ls_addr = la; e.strobe = strobe; e.wdata = wdata; e.data = data;
        return e;
    endfunction

    // Reference model: derives arbiter fields and the result from the ISA rules with plain arithmetic.
    function automatic exp_t model(req_t r);
        exp_t        e;
        int          sz;
        int          off;
        logic [31:0] v;
        if (r.st) sz = (r.f3 == 0) ? 1 : (r.f3 == 1) ? 2 : 4;
        else      sz = (r.f3 == 0 || r.f3 == 4) ? 1 : (r.f3 == 1 || r.f3 == 5) ? 2 : 4;
        off = int'(r.addr % 4);
        e = mk_exp(0, r.addr - off, 4'd0, 32'h0, 32'h0);
`ifdef LSU_MISALIGN_TRAP_EN
        if ((sz == 2 && off % 2 != 0) || (sz == 4 && off != 0)) begin
            e.fault = 1;
            e.data  = r.addr;
            return e;
        end
`endif
        if (r.st) begin
            if (sz == 1) begin
                e.strobe = 4'(1 << off);
                e.wdata  = (r.wdata & 32'hFF) * 32'h0101_0101;
            end else if (sz == 2) begin
                e.strobe = 4'(3 << ((off / 2) * 2));
                e.wdata  = (r.wdata & 32'hFFFF) * 32'h0001_0001;
            end else begin
                e.strobe = 4'hF;
                e.wdata  = r.wdata;
            end
            e.data = 32'h0;
        end else begin
            if (sz == 1) begin
                v = (r.ld >> (8 * off)) & 32'hFF;
                if (r.f3 == 0 && v >= 128) v = v - 256;
            end else if (sz == 2) begin
                v = (r.ld >> (16 * (off / 2))) & 32'hFFFF;
                if (r.f3 == 1 && v >= 32768) v = v - 65536;
            end else begin
                v = r.ld;
            end
            e.data = v;
        end
        return e;
    endfunction

    task automatic run_txn(input req_t r, input exp_t e, input string tag);
        int hs0;
        @(negedge CLK);
        check({tag, "/req_ready_idle"}, 32'(req_ready), 32'd1);
        hs0 = hs_count;
        req_valid    = 1'b1;
        req_is_store = r.st;
        req_funct3   = r.f3;
        req_addr     = r.addr;
        req_wdata    = r.wdata;
        req_rd       = r.rd;
        @(negedge CLK);
        req_valid = 1'b0;
        req_addr  = ~r.addr;
        req_wdata = ~r.wdata;
        req_rd    = ~r.rd;
        if (e.fault) begin
            check({tag, "/no_ls_valid"}, 32'(ls_valid), 32'd0);
        end else begin
            check({tag, "/ls_valid"}, 32'(ls_valid), 32'd1);
            check({tag, "/req_ready_busy"}, 32'(req_ready), 32'd0);
            for (int i = 0; i <= r.ls_stall; i++) begin
                if (i > 0) @(negedge CLK);
                check({tag, "/ls_valid_held"}, 32'(ls_valid), 32'd1);
                check({tag, "/ls_addr"}, ls_addr, e.ls_addr);
                check({tag, "/ls_strobe"}, 32'(ls_strobe), 32'(e.strobe));
                check({tag, "/ls_is_write"}, 32'(ls_is_write), 32'(r.st));
                if (r.st) check({tag, "/ls_wdata"}, ls_wdata, e.wdata);
            end
            ls_ready = 1'b1;
            @(negedge CLK);
            ls_ready = 1'b0;
            check({tag, "/wait_ls_valid_low"}, 32'(ls_valid), 32'd0);
            check({tag, "/wait_result_ready"}, 32'(ls_result_ready), 32'd1);
            ls_load_data    = r.ld;
            ls_result_valid = 1'b1;
            @(negedge CLK);
            ls_result_valid = 1'b0;
            ls_load_data    = $urandom;
        end
        for (int i = 0; i <= r.resp_stall; i++) begin
            if (i > 0) @(negedge CLK);
            check({tag, "/resp_valid"}, 32'(resp_valid), 32'd1);
            check({tag, "/resp_data"}, resp_data, e.data);
            check({tag, "/resp_rd"}, 32'(resp_rd), 32'(r.rd));
            check({tag, "/resp_misaligned"}, 32'(resp_misaligned), 32'(e.fault));
            check({tag, "/resp_req_ready"}, 32'(req_ready), 32'd0);
        end
        resp_ready = 1'b1;
        @(negedge CLK);
        resp_ready = 1'b0;
        check({tag, "/resp_done"}, 32'(resp_valid), 32'd0);
        check({tag, "/req_ready_after"}, 32'(req_ready), 32'd1);
        check({tag, "/handshakes"}, 32'(hs_count - hs0), e.fault ? 32'd0 : 32'd1);
    endtask

    initial begin
        req_t r;
        exp_t e;

        tbl[0].r  = mk_req(0, 3'b000, 32'h103, 32'h0, 32'h80FF_0000, 5'd5, 0, 5);
        tbl[0].e  = mk_exp(0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_FF80);
        tbl[1].r  = mk_req(1, 3'b001, 32'h202, 32'h0000_BEEF, 32'h0, 5'd6, 3, 0);
        tbl[1].e  = mk_exp(0, 32'h200, 4'b1100, 32'hBEEF_BEEF, 32'h0);
        tbl[2].r  = mk_req(0, 3'b100, 32'h101, 32'h0, 32'h1234_8056, 5'd7, 1, 1);
        tbl[2].e  = mk_exp(0, 32'h100, 4'b0000, 32'h0, 32'h0000_0080);
        tbl[3].r  = mk_req(0, 3'b001, 32'h102, 32'h0, 32'h8001_7FFF, 5'd8, 0, 0);
        tbl[3].e  = mk_exp(0, 32'h100, 4'b0000, 32'h0, 32'hFFFF_8001);
        tbl[4].r  = mk_req(0, 3'b101, 32'h100, 32'h0, 32'h8001_F00D, 5'd9, 0, 0);
        tbl[4].e  = mk_exp(0, 32'h100, 4'b0000, 32'h0, 32'h0000_F00D);
        tbl[5].r  = mk_req(0, 3'b010, 32'h300, 32'h0, 32'hDEAD_BEEF, 5'd10, 2, 2);
        tbl[5].e  = mk_exp(0, 32'h300, 4'b0000, 32'h0, 32'hDEAD_BEEF);
        tbl[6].r  = mk_req(1, 3'b000, 32'h401, 32'h1234_56A5, 32'h0, 5'd11, 0, 0);
        tbl[6].e  = mk_exp(0, 32'h400, 4'b0010, 32'hA5A5_A5A5, 32'h0);
        tbl[7].r  = mk_req(1, 3'b010, 32'h500, 32'hCAFE_F00D, 32'h0, 5'd12, 1, 0);
        tbl[7].e  = mk_exp(0, 32'h500, 4'b1111, 32'hCAFE_F00D, 32'h0);
        tbl[8].r  = mk_req(0, 3'b111, 32'h600, 32'h0, 32'h1122_3344, 5'd13, 0, 1);
        tbl[8].e  = mk_exp(0, 32'h600, 4'b0000, 32'h0, 32'h1122_3344);
        tbl[9].r  = mk_req(1, 3'b101, 32'h704, 32'h5566_7788, 32'h0, 5'd14, 0, 0);
        tbl[9].e  = mk_exp(0, 32'h704, 4'b1111, 32'h5566_7788, 32'h0);
        tbl[10].r = mk_req(0, 3'b000, 32'h100, 32'h0, 32'h0000_007F, 5'd15, 0, 0);
        tbl[10].e = mk_exp(0, 32'h100, 4'b0000, 32'h0, 32'h0000_007F);
        tbl[11].r = mk_req(1, 3'b001, 32'h200, 32'h1234_ABCD, 32'h0, 5'd31, 0, 0);
        tbl[11].e = mk_exp(0, 32'h200, 4'b0011, 32'hABCD_ABCD, 32'h0);

        // Outputs while reset is held.
        #3;
        check("rst/req_ready", 32'(req_ready), 32'd1);
        check("rst/resp_valid", 32'(resp_valid), 32'd0);
        check("rst/ls_valid", 32'(ls_valid), 32'd0);
        check("rst/ls_result_ready", 32'(ls_result_ready), 32'd0);
        check("rst/resp_data", resp_data, 32'd0);
        check("rst/resp_rd", 32'(resp_rd), 32'd0);
        check("rst/resp_misaligned", 32'(resp_misaligned), 32'd0);
        check("rst/ls_strobe", 32'(ls_strobe), 32'd0);
        check("rst/ls_addr", ls_addr, 32'd0);
        @(negedge CLK);
        RST = 1'b0;

        // A stray completion pulse while idle must be ignored.
        @(negedge CLK);
        ls_result_valid = 1'b1;
        ls_load_data    = 32'h1234_5678;
        @(negedge CLK);
        ls_result_valid = 1'b0;
        check("idle_pulse/resp_valid", 32'(resp_valid), 32'd0);
        check("idle_pulse/req_ready", 32'(req_ready), 32'd1);

        for (int i = 0; i < 12; i++) run_txn(tbl[i].r, tbl[i].e, $sformatf("vec%0d", i));

        // LW at a misaligned word address.
        r = mk_req(0, 3'b010, 32'h206, 32'h0, 32'hAABB_CCDD, 5'd3, 0, 1);
`ifdef LSU_MISALIGN_TRAP_EN
        e = mk_exp(1, 32'h0, 4'b0000, 32'h0, 32'h0000_0206);
`else
        e = mk_exp(0, 32'h204, 4'b0000, 32'h0, 32'hAABB_CCDD);
`endif
        run_txn(r, e, "lw_206");

        // Reset asserted mid-WAIT, then a late completion pulse.
        @(negedge CLK);
        req_valid = 1'b1; req_is_store = 1'b0; req_funct3 = 3'b010;
        req_addr = 32'h800; req_rd = 5'd21;
        @(negedge CLK);
        req_valid = 1'b0;
        ls_ready  = 1'b1;
        @(negedge CLK);
        ls_ready = 1'b0;
        check("rstwait/in_wait", 32'(ls_result_ready), 32'd1);
        #2 RST = 1'b1;
        #1;
        check("rstwait/req_ready_async", 32'(req_ready), 32'd1);
        check("rstwait/ls_result_ready", 32'(ls_result_ready), 32'd0);
        check("rstwait/resp_rd", 32'(resp_rd), 32'd0);
        @(negedge CLK);
        RST = 1'b0;
        ls_result_valid = 1'b1;
        ls_load_data    = 32'hFFFF_FFFF;
        @(negedge CLK);
        ls_result_valid = 1'b0;
        check("rstwait/resp_valid", 32'(resp_valid), 32'd0);
        check("rstwait/req_ready", 32'(req_ready), 32'd1);
        check("rstwait/ls_valid", 32'(ls_valid), 32'd0);
        check("rstwait/resp_data", resp_data, 32'd0);

        // Randomized transactions against the model.
        for (int i = 0; i < 40; i++) begin
            r = mk_req(1'($urandom_range(0, 1)), 3'($urandom_range(0, 7)), $urandom & 32'h0000_FFFF,
                       $urandom, $urandom, 5'($urandom_range(0, 31)),
                       int'($urandom_range(0, 3)), int'($urandom_range(0, 3)));
            e = model(r);
            run_txn(r, e, $sformatf("rnd%0d", i));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
